deci_filter_dma_arbiter: RTL
============================

DECI_FILTER_DMA_ARBITER -- requirements
Module: deci_filter_dma_arbiter

Interface
REQ-001 Parameter TO_W, default 16, SHALL set the width of the watchdog counter and of Timeout_Limit_i.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
  WBs_CLK_i  in  1  fabric clock; the only clock.
  WBs_RST_i  in  1  reset; asynchronous, active-high.
  Arb_EN_i  in  1  arbiter enable; low = synchronous clear.
  Req_i  in  2  DMA request from requester n (bit n).
  Done_i  in  2  one-cycle DMA done pulse from requester n.
  SDMA_Active_i  in  1  active indication from the shared SDMA channel.
  Timeout_Limit_i  in  TO_W  watchdog limit in clocks; 0 disables the watchdog.
  SDMA_Req_o  out  1  request to the shared SDMA channel.
  Active_o  out  2  SDMA_Active_i routed to the granted requester only.
  Gnt_o  out  2  one-hot grant; 0 when no owner.
  Timeout_o  out  1  sticky watchdog-expiry flag.
  Xfr_Cnt_o  out  8  count of completed grants, wraps 255->0.
  Arb_St_o  out  2  current state, for debug.

Function
REQ-003 The state machine SHALL have states IDLE=0, GRANT=1, XFR=2, RELEASE=3.
REQ-004 IDLE: when any Req_i bit is high, the arbiter SHALL select the owner, set Gnt_o one-hot and go to GRANT in the next clock.
REQ-005 Selection SHALL be round-robin: when both bits request, the requester not served by the last grant wins; after reset, requester 0 wins.
REQ-006 GRANT: SDMA_Req_o SHALL be 1; when SDMA_Active_i=1, the next state SHALL be XFR and SDMA_Req_o SHALL drop in that same next clock.
REQ-007 GRANT: if the owner's Req_i drops before SDMA_Active_i rises, the arbiter SHALL go to RELEASE without counting a transfer.
REQ-008 XFR: SDMA_Req_o SHALL be 0; on Done_i of the owner, the next state SHALL be RELEASE and Xfr_Cnt_o SHALL increment by 1.
REQ-009 Done_i from a requester that is not the owner SHALL be ignored in every state.
REQ-010 RELEASE SHALL last exactly one clock: Gnt_o=0, SDMA_Req_o=0, the last-served pointer updates to the owner, and the next state is IDLE.
REQ-011 A new grant SHALL therefore be issued no earlier than 2 clocks after the Done_i pulse.
REQ-012 Active_o[n] SHALL equal SDMA_Active_i AND Gnt_o[n], combinationally; Active_o SHALL be 0 for the other requester.
REQ-013 Watchdog: the counter SHALL clear on entry to GRANT and increment each clock in GRANT or XFR.
REQ-014 If Timeout_Limit_i is nonzero and the counter equals Timeout_Limit_i, the arbiter SHALL set Timeout_o=1 and go to RELEASE, with no Xfr_Cnt_o increment.
REQ-015 The watchdog counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-016 Timeout_o SHALL clear only by reset or by Arb_EN_i=0.
REQ-017 Owner Done_i and watchdog expiry in the same clock: the transfer SHALL be counted and Timeout_o SHALL NOT be set.
REQ-018 Arb_EN_i=0 in any state: the next clock SHALL force IDLE, Gnt_o=0, SDMA_Req_o=0, Timeout_o=0 and watchdog=0; Xfr_Cnt_o and the last-served pointer SHALL be held.
REQ-019 Req_i changes in XFR or RELEASE SHALL NOT alter the current owner.

Reset
REQ-020 While WBs_RST_i=1, asynchronously: state IDLE, Gnt_o=0, SDMA_Req_o=0, Timeout_o=0, Xfr_Cnt_o=0, watchdog=0, last-served=1 (so requester 0 wins first).
REQ-021 Reset asserted mid-transfer SHALL take effect immediately, with no RELEASE cycle; Active_o SHALL read 0 because Gnt_o=0.

Verification
REQ-022 Single request: Req_i=01; Active rises 3 clocks after GRANT; Done_i[0] pulse -> Gnt_o=01 through XFR, then RELEASE, then IDLE; Xfr_Cnt_o=1.
REQ-023 Contention: Req_i=11 held for 4 transfers -> grant order 0,1,0,1; Xfr_Cnt_o=4.
REQ-024 Watchdog: Timeout_Limit_i=10 and SDMA_Active_i never rises -> RELEASE at the 10th GRANT clock; Timeout_o=1 and sticky; Xfr_Cnt_o unchanged.
REQ-025 Stray and simultaneous events: Done_i[1] while requester 0 owns -> ignored; owner Done_i on the same clock as expiry -> count +1 and Timeout_o=0.
REQ-026 Disable/reset mid-XFR: Arb_EN_i=0 -> next clock IDLE with Gnt_o=0 and Xfr_Cnt_o held; async WBs_RST_i pulse -> all outputs 0 immediately.
REQ-027 Wrap: 256 completed transfers -> Xfr_Cnt_o=0.

Source files
------------

// File: rtl/deci_filter_dma_arbiter.sv
// deci_filter_dma_arbiter: round-robin arbiter sharing one SDMA channel between two requesters,
// with a per-grant watchdog and a completed-transfer counter.
module deci_filter_dma_arbiter #(
    parameter int TO_W = 16
) (
    input  logic            WBs_CLK_i,
    input  logic            WBs_RST_i,
    input  logic            Arb_EN_i,
    input  logic [1:0]      Req_i,
    input  logic [1:0]      Done_i,
    input  logic            SDMA_Active_i,
    input  logic [TO_W-1:0] Timeout_Limit_i,
    output logic            SDMA_Req_o,
    output logic [1:0]      Active_o,
    output logic [1:0]      Gnt_o,
    output logic            Timeout_o,
    output logic [7:0]      Xfr_Cnt_o,
    output logic [1:0]      Arb_St_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, XFR = 2'd2, RELEASE = 2'd3} st_t;

    st_t             st_q;
    logic            owner_q, last_q, sreq_q, to_q;
    logic [1:0]      gnt_q;
    logic [7:0]      cnt_q;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            expire, pick;

    // wd_d is the number of clocks spent owning the channel, including this one
    assign wd_d   = &wd_q ? wd_q : wd_q + 1'b1;
    assign expire = (Timeout_Limit_i != '0) && (wd_d == Timeout_Limit_i);
    assign pick   = &Req_i ? ~last_q : Req_i[1];

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            st_q    <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sreq_q  <= 1'b0;
            to_q    <= 1'b0;
            gnt_q   <= 2'b00;
            cnt_q   <= 8'd0;
            wd_q    <= '0;
        end else if (!Arb_EN_i) begin
            st_q   <= IDLE;
            sreq_q <= 1'b0;
            to_q   <= 1'b0;
            gnt_q  <= 2'b00;
            wd_q   <= '0;
        end else begin
            case (st_q)
                IDLE: if (|Req_i) begin
                    st_q    <= GRANT;
                    owner_q <= pick;
                    gnt_q   <= pick ? 2'b10 : 2'b01;
                    sreq_q  <= 1'b1;
                    wd_q    <= '0;
                end
                GRANT: begin
                    wd_q <= wd_d;
                    if (expire) begin
                        st_q   <= RELEASE;
                        to_q   <= 1'b1;
                        gnt_q  <= 2'b00;
                        sreq_q <= 1'b0;
                    end else if (SDMA_Active_i) begin
                        st_q   <= XFR;
                        sreq_q <= 1'b0;
                    end else if (!Req_i[owner_q]) begin
                        st_q   <= RELEASE;
                        gnt_q  <= 2'b00;
                        sreq_q <= 1'b0;
                    end
                end
                XFR: begin
                    wd_q <= wd_d;
                    // a completing transfer wins over a simultaneous watchdog expiry
                    if (Done_i[owner_q]) begin
                        st_q  <= RELEASE;
                        gnt_q <= 2'b00;
                        cnt_q <= cnt_q + 8'd1;
                    end else if (expire) begin
                        st_q  <= RELEASE;
                        to_q  <= 1'b1;
                        gnt_q <= 2'b00;
                    end
                end
                default: begin
                    last_q <= owner_q;
                    st_q   <= IDLE;
                end
            endcase
        end
    end

    assign SDMA_Req_o = sreq_q;
    assign Gnt_o      = gnt_q;
    assign Active_o   = {2{SDMA_Active_i}} & gnt_q;
    assign Timeout_o  = to_q;
    assign Xfr_Cnt_o  = cnt_q;
    assign Arb_St_o   = st_q;
endmodule
